mips_prog_loader: RTL and testbench

//  Boot-time program/data loader directly upstream of the multicycle MIPS core.

---
 rtl/mips_prog_loader.sv | 132 +++++++++++++
 tb/tb_mips_prog_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_prog_loader.sv
// mips_prog_loader: boot-time byte-stream loader that fills the MIPS unified RAM and gates the core reset
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   in_valid     in_byte is valid
//   in_ready     loader accepts a byte when in_valid & in_ready
//   in_byte      stream byte
//   mem_we       one-cycle RAM write strobe
//   mem_addr     RAM word address (held when mem_we=0)
//   mem_wdata    RAM write data (held when mem_we=0)
//   load_active  1 = loader owns the RAM port
//   cpu_rst      active-high reset to the MIPS core
//   done         1 while the core is running
//   err          sticky error flag, cleared only by rst
//
// Frame: A5, ADDR[15:8], ADDR[7:0], CNT[15:8], CNT[7:0], CNT*4 data bytes (big-endian words).
// In IDLE, 5A starts the core; in RUN, C3 halts it. Inside a frame every byte is data.
module mips_prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_byte,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              load_active,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, A_HI, A_LO, C_HI, C_LO, DATA, RUN} state_t;

    localparam logic [16:0] MW = 17'(MEM_WORDS);

    state_t      state, state_nx;
    logic        acc;
    logic [15:0] base;
    logic [15:0] cnt;
    logic [15:0] k;
    logic [1:0]  bcnt;
    logic [23:0] sh;
    logic [15:0] waddr;
    logic        in_range;
    logic        last_word;
    logic        cnt_zero;

    assign acc       = in_valid & in_ready;
    // Target address is formed in 16 bits; anything past the RAM is dropped and flagged.
    assign waddr     = base + k;
    assign in_range  = {1'b0, waddr} < MW;
    assign last_word = k == cnt - 16'd1;
    // CNT low byte is still on in_byte when the C_LO decision is made.
    assign cnt_zero  = {cnt[15:8], in_byte} == 16'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (acc) begin
            case (state)
                IDLE:    state_nx = (in_byte == 8'hA5) ? A_HI : (in_byte == 8'h5A) ? RUN : IDLE;
                A_HI:    state_nx = A_LO;
                A_LO:    state_nx = C_HI;
                C_HI:    state_nx = C_LO;
                C_LO:    state_nx = cnt_zero ? IDLE : DATA;
                DATA:    state_nx = (bcnt == 2'd3 && last_word) ? IDLE : DATA;
                RUN:     state_nx = (in_byte == 8'hC3) ? IDLE : RUN;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        cpu_rst     = state != RUN;
        load_active = state != RUN;
        done        = state == RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            base      <= '0;
            cnt       <= '0;
            k         <= '0;
            bcnt      <= '0;
            sh        <= '0;
        end else begin
            in_ready <= 1'b1;
            mem_we   <= 1'b0;
            if (acc) begin
                case (state)
                    IDLE: err <= err | (in_byte != 8'hA5 && in_byte != 8'h5A);
                    A_HI: base[15:8] <= in_byte;
                    A_LO: base[7:0] <= in_byte;
                    C_HI: cnt[15:8] <= in_byte;
                    C_LO: begin
                        cnt[7:0] <= in_byte;
                        k        <= '0;
                        bcnt     <= '0;
                    end
                    DATA: begin
                        bcnt <= bcnt + 2'd1;
                        sh   <= {sh[15:0], in_byte};
                        if (bcnt == 2'd3) begin
                            k <= k + 16'd1;
                            if (in_range) begin
                                mem_we    <= 1'b1;
                                mem_addr  <= waddr[ADDR_W-1:0];
                                mem_wdata <= {sh, in_byte};
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mips_prog_loader.sv
// tb_mips_prog_loader: randomized scoreboard bench for the boot loader
module tb_mips_prog_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        load_active;
    logic        cpu_rst;
    logic        done;
    logic        err;

    mips_prog_loader #(.ADDR_W(10), .MEM_WORDS(1024)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .load_active(load_active), .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    bit exp_err = 1'b0;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
        int          c;
    } wr_t;
    wr_t q[$];
    wr_t e;
    logic [31:0] wbuf[64];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Every strobe must match the oldest expected write, including the edge it lands on.
    always @(negedge clk) begin
        if (rst && mem_we) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write (t=%0t)", mem_addr, mem_wdata, $time);
            end else begin
                e = q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.a));
                chk("wr_data", mem_wdata, e.d);
                chk("wr_cycle", cyc, e.c);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the byte is taken.
    task automatic send(input logic [7:0] b, input bit wr = 1'b0, input int wa = 0, input logic [31:0] w = 0);
        int g;
        g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        in_valid = 1'b0;
        repeat (g) @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        for (int i = 0; i < 8 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0 expected 1 (t=%0t)", $time);
        end
        if (wr) begin
            if (wa < 1024) q.push_back('{wa[9:0], w, cyc + 1});
            else exp_err = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic frame(input int a, input int n);
        logic [31:0] w;
        int wa;
        send(8'hA5);
        send(a[15:8]);
        send(a[7:0]);
        send(n[15:8]);
        send(n[7:0]);
        for (int k = 0; k < n; k++) begin
            w  = wbuf[k];
            wa = (a + k) % 65536;
            send(w[31:24]);
            send(w[23:16]);
            send(w[15:8]);
            send(w[7:0], 1'b1, wa, w);
        end
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) wbuf[i] = $urandom;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_load_active", 32'(load_active), 1);
        chk("rst_cpu_rst", 32'(cpu_rst), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        repeat (2) @(negedge clk);
        chk("rst_in_ready_low", 32'(in_ready), 0);
        rst = 1'b1;
        exp_err = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 1);
    endtask

    initial begin
        logic [7:0] jb;
        int a, n;
        do_reset();

        // T1: 22-word program at address 0
        fill(22);
        wbuf[0]  = 32'h00000000;
        wbuf[1]  = 32'h20190200;
        wbuf[21] = 32'h02D29006;
        frame(0, 22);
        chk("t1_err", 32'(err), 0);
        chk("t1_cpu_rst", 32'(cpu_rst), 1);

        // T2: single word at 527, then GO
        wbuf[0] = 32'h00000005;
        frame(16'h020F, 1);
        send(8'h5A);
        chk("t2_cpu_rst", 32'(cpu_rst), 0);
        chk("t2_done", 32'(done), 1);
        chk("t2_load_active", 32'(load_active), 0);

        // T6: RUN ignores everything but HALT
        send(8'h5A);
        chk("t6_cpu_rst_a", 32'(cpu_rst), 0);
        send(8'hA5);
        chk("t6_cpu_rst_b", 32'(cpu_rst), 0);
        send(8'hC3);
        chk("t6_cpu_rst_halt", 32'(cpu_rst), 1);
        chk("t6_load_active", 32'(load_active), 1);
        chk("t6_done", 32'(done), 0);

        // T4: stray byte in IDLE, then a normal frame
        send(8'h7E);
        exp_err = 1'b1;
        chk("t4_err", 32'(err), 32'(exp_err));
        fill(1);
        frame(5, 1);

        // command codes inside frame data are plain data
        wbuf[0] = 32'h5AC3A55A;
        wbuf[1] = 32'hC35A5AC3;
        frame(100, 2);
        chk("cmd_in_data_cpu_rst", 32'(cpu_rst), 1);
        chk("cmd_in_data_done", 32'(done), 0);

        // T3: CNT=0, then a frame straddling the top of memory
        do_reset();
        frame(0, 0);
        chk("t3_cnt0_err", 32'(err), 0);
        fill(2);
        frame(16'h03FF, 2);
        chk("t3_err", 32'(err), 32'(exp_err));
        fill(1);
        frame(7, 1);

        // T5: reset after two data bytes of the second word
        do_reset();
        fill(2);
        send(8'hA5); send(8'h00); send(8'h10); send(8'h00); send(8'h02);
        send(wbuf[0][31:24]); send(wbuf[0][23:16]); send(wbuf[0][15:8]);
        send(wbuf[0][7:0], 1'b1, 16, wbuf[0]);
        send(wbuf[1][31:24]); send(wbuf[1][23:16]);
        do_reset();
        fill(3);
        frame(16, 3);
        chk("t5_err", 32'(err), 0);

        // randomized frames, occasionally running and halting the core
        for (int it = 0; it < 20; it++) begin
            a = $urandom_range(0, 1100);
            n = $urandom_range(0, 4);
            fill(n);
            frame(a, n);
            chk("rnd_err", 32'(err), 32'(exp_err));
            if ($urandom_range(0, 3) == 0) begin
                send(8'h5A);
                chk("rnd_done_go", 32'(done), 1);
                jb = 8'($urandom);
                if (jb == 8'hC3) jb = 8'h00;
                send(jb);
                chk("rnd_cpu_rst_run", 32'(cpu_rst), 0);
                send(8'hC3);
                chk("rnd_done_halt", 32'(done), 0);
            end
        end

        repeat (3) @(negedge clk);
        chk("pending_writes", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
